multi_channel_watchdog: RTL and testbench
=========================================

Name: multi_channel_watchdog

Overview:
Parametrised successor to the single-channel watchdog timer. It runs NUM_CH independent heartbeat monitors, each with its own enable. Each channel has a staged warning/trip escalation, a sticky trip flag and a per-channel clear. A shared fixed-length force_reset pulse is generated on any new trip, and the faulting channel index is reported. Sits between the control-plane heartbeat sources and the system reset controller.

Parameters:
NUM_CH, 4, number of monitored channels (1..16)
CNT_W, 16, width of each per-channel cycle counter
TIMEOUT_CYCLES, 1000, cycles without heartbeat before trip; must satisfy WARN_CYCLES < TIMEOUT_CYCLES < 2**CNT_W
WARN_CYCLES, 750, counter value at or above which warning asserts
RST_PULSE, 8, force_reset pulse length in cycles (>=1)
WINDOW_MIN, 100, earliest legal heartbeat count (used only with WDT_WINDOW_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  NUM_CH  per-channel monitor enable
heartbeat  in  NUM_CH  per-channel kick, sampled on rising clk edge
clr  in  NUM_CH  per-channel clear of sticky trip, one-cycle strobe
warning  out  NUM_CH  channel counter >= WARN_CYCLES while in RUN
triggered  out  NUM_CH  sticky per-channel trip flag
force_reset  out  1  reset request pulse, RST_PULSE cycles
fault_ch  out  $clog2(NUM_CH) (min 1)  lowest index of the first trip event since last full clear
fault_valid  out  1  fault_ch is meaningful

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all counters 0, all channels IDLE, warning=0, triggered=0, force_reset=0, fault_ch=0, fault_valid=0. Reset mid-pulse aborts force_reset on the next edge.
- Per-channel FSM, states IDLE, RUN, TRIPPED:
  - IDLE: counter held at 0. Goes to RUN when enable=1.
  - RUN, enable=0: go to IDLE, counter to 0.
  - RUN, heartbeat=1 or clr=1: counter to 0 next cycle.
  - RUN, counter==TIMEOUT_CYCLES-1 and no heartbeat: go to TRIPPED.
  - RUN, otherwise: counter increments by 1.
  - TRIPPED: counter frozen. Stays TRIPPED regardless of enable or heartbeat. Leaves only on clr=1 (to IDLE, counter to 0) or rst.
- Trip timing: from the last heartbeat cycle with no further kicks, triggered rises exactly TIMEOUT_CYCLES+1 edges later.
- Heartbeat vs trip: a heartbeat in the same cycle as the trip condition wins, and no trip occurs.
- Outputs are registered: warning = (state==RUN && counter>=WARN_CYCLES); triggered = (state==TRIPPED).
- force_reset:
  - A pulse counter loads RST_PULSE on the cycle any channel enters TRIPPED. force_reset asserts for exactly RST_PULSE cycles starting the next cycle.
  - New trips while the pulse is active do not extend or retrigger it.
  - A trip on the cycle the pulse ends starts a fresh pulse with no gap cycle.
- fault_ch / fault_valid:
  - Captured on the first trip event while fault_valid=0. If several channels trip simultaneously, the lowest index wins.
  - Held until all triggered bits are 0 after clears, then fault_valid goes to 0 the following cycle.
- Counter never wraps; TIMEOUT bound guarantees the counter does not saturate.

Optional Feature:
WDT_WINDOW_EN
- Defined: window-watchdog mode. A heartbeat in RUN while counter < WINDOW_MIN is an early kick. It trips the channel on the next edge, with the same effects as a timeout: force_reset pulse and fault capture. An added output early_kick (NUM_CH bits) is a sticky per-channel flag of the cause, cleared with clr.
- Undefined: any heartbeat in RUN resets the counter. WINDOW_MIN is ignored and the early_kick port does not exist.

Test Plan:
Common configuration: NUM_CH=4, CNT_W=8, TIMEOUT_CYCLES=16, WARN_CYCLES=12, RST_PULSE=4.
1. Reset, then enable[0]=1, heartbeat=0 -> warning[0] rises on the 13th edge after enable; triggered[0] rises on the 17th; force_reset=1 for exactly 4 cycles; fault_ch=0, fault_valid=1.
2. enable[1]=1, heartbeat[1] every 10 cycles for 200 cycles -> warning, triggered and force_reset stay 0 throughout.
3. Channels 2 and 3 enabled on the same cycle with no kicks -> both trip on the same edge; fault_ch=2; one 4-cycle pulse only.
4. Channel 0 trips; then clr[0] pulsed, enable[0] kept high -> triggered[0]=0 and fault_valid=0 next cycle; the channel re-arms and trips again 17 edges later.
5. heartbeat[0] asserted on the exact trip cycle (counter=15) -> no trip; counter returns to 0. Separately, rst asserted during a force_reset pulse -> all outputs 0 next edge.
6. WDT_WINDOW_EN, WINDOW_MIN=5: kick at counter=3 -> triggered[0]=1 and early_kick[0]=1 next cycle. Kick at counter=8 -> counter resets and no trip.

Source files
------------

// File: rtl/multi_channel_watchdog.sv
// NUM_CH independent heartbeat watchdogs with warning, sticky trip, shared force_reset pulse and fault capture.
// Optional WDT_WINDOW_EN: a heartbeat before WINDOW_MIN counts trips the channel and sets early_kick.
module multi_channel_watchdog #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int WARN_CYCLES    = 750,
  parameter int RST_PULSE      = 8,
  parameter int WINDOW_MIN     = 100,
  localparam int FW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] triggered,
  output logic              force_reset,
  output logic [FW-1:0]     fault_ch,
  output logic              fault_valid
`ifdef WDT_WINDOW_EN
  ,
  output logic [NUM_CH-1:0] early_kick
`endif
);

  localparam int PW = $clog2(RST_PULSE + 1);
`ifdef WDT_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, TRIPPED} state_t;

  state_t            state_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] go_trip;
  logic [NUM_CH-1:0] early_now;
  logic [NUM_CH-1:0] next_trig;
  logic [FW-1:0]     low_idx;
  logic [PW-1:0]     pulse_q;

  // A heartbeat or clear in the trip cycle takes priority over the timeout.
  always_comb begin
    go_trip   = '0;
    early_now = '0;
    next_trig = '0;
    low_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      early_now[i] = WIN_EN && (state_q[i] == RUN) && enable[i] && heartbeat[i] &&
                     (cnt_q[i] < CNT_W'(WINDOW_MIN));
      go_trip[i]   = early_now[i] ||
                     ((state_q[i] == RUN) && enable[i] && !heartbeat[i] && !clr[i] &&
                      (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)));
      next_trig[i] = go_trip[i] || ((state_q[i] == TRIPPED) && !clr[i]);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (go_trip[i]) low_idx = FW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      warning     <= '0;
      triggered   <= '0;
      pulse_q     <= '0;
      force_reset <= 1'b0;
      fault_ch    <= '0;
      fault_valid <= 1'b0;
`ifdef WDT_WINDOW_EN
      early_kick  <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (state_q[i])
          IDLE: begin
            cnt_q[i]   <= '0;
            warning[i] <= 1'b0;
            if (enable[i]) state_q[i] <= RUN;
          end
          RUN: begin
            if (!enable[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
              warning[i] <= 1'b0;
            end else if (go_trip[i]) begin
              state_q[i] <= TRIPPED;
              warning[i] <= 1'b0;
            end else if (heartbeat[i] || clr[i]) begin
              cnt_q[i]   <= '0;
              warning[i] <= 1'b0;
            end else begin
              cnt_q[i]   <= cnt_q[i] + 1'b1;
              warning[i] <= (cnt_q[i] >= CNT_W'(WARN_CYCLES - 1));
            end
          end
          TRIPPED: begin
            if (clr[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            warning[i] <= 1'b0;
          end
        endcase
      end

      triggered <= next_trig;

      // Reload only when idle or in the last pulse cycle, so pulses never stretch but chain gaplessly.
      if ((|go_trip) && (pulse_q <= PW'(1))) begin
        pulse_q     <= PW'(RST_PULSE);
        force_reset <= 1'b1;
      end else if (pulse_q != '0) begin
        pulse_q     <= pulse_q - 1'b1;
        force_reset <= (pulse_q > PW'(1));
      end else begin
        force_reset <= 1'b0;
      end

      if (next_trig == '0) begin
        fault_valid <= 1'b0;
      end else if (!fault_valid) begin
        fault_valid <= 1'b1;
        fault_ch    <= low_idx;
      end

`ifdef WDT_WINDOW_EN
      early_kick <= (early_kick & ~clr) | early_now;
`endif
    end
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Randomized + directed bench for multi_channel_watchdog; scoreboard queue filled by the stimulus, drained by a monitor.
module tb_multi_channel_watchdog;
  localparam int NUM_CH = 4;
  localparam int TO     = 16;
  localparam int WARN   = 12;
  localparam int RP     = 4;
  localparam int WMIN   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] enable = '0, heartbeat = '0, clr = '0;
  logic [3:0] warning, triggered;
  logic       force_reset, fault_valid;
  logic [1:0] fault_ch;
`ifdef WDT_WINDOW_EN
  logic [3:0] early_kick;
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  multi_channel_watchdog #(
    .NUM_CH(NUM_CH), .CNT_W(8), .TIMEOUT_CYCLES(TO), .WARN_CYCLES(WARN),
    .RST_PULSE(RP), .WINDOW_MIN(WMIN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat), .clr(clr),
    .warning(warning), .triggered(triggered), .force_reset(force_reset),
    .fault_ch(fault_ch), .fault_valid(fault_valid)
`ifdef WDT_WINDOW_EN
    , .early_kick(early_kick)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] warning, triggered, early;
    logic       force_reset, fault_valid;
    logic [1:0] fault_ch;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: per-channel "armed / tripped" flags plus age since last kick.
  bit   m_armed[4], m_trip[4], m_early[4];
  int   m_age[4];
  int   m_pulse_left = 0;
  bit   m_fv = 0;
  int   m_fch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic [3:0] en, input logic [3:0] hb, input logic [3:0] cl, input logic r);
    logic [3:0] new_trip;
    bit any_trip;
    exp_t e;
    new_trip = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_armed[i] = 0; m_trip[i] = 0; m_early[i] = 0; m_age[i] = 0;
      end
      m_pulse_left = 0; m_fv = 0; m_fch = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_trip[i]) begin
          if (cl[i]) begin m_trip[i] = 0; m_early[i] = 0; m_age[i] = 0; end
        end else if (!m_armed[i]) begin
          if (en[i]) begin m_armed[i] = 1; m_age[i] = 0; end
        end else if (!en[i]) begin
          m_armed[i] = 0; m_age[i] = 0;
        end else if (WIN && hb[i] && m_age[i] < WMIN) begin
          m_armed[i] = 0; m_trip[i] = 1; m_early[i] = 1; new_trip[i] = 1'b1;
        end else if (hb[i] || cl[i]) begin
          m_age[i] = 0;
        end else if (m_age[i] == TO - 1) begin
          m_armed[i] = 0; m_trip[i] = 1; new_trip[i] = 1'b1;
        end else begin
          m_age[i]++;
        end
      end
      if (new_trip != 0 && m_pulse_left <= 1) m_pulse_left = RP;
      else if (m_pulse_left > 0) m_pulse_left--;
      any_trip = 0;
      for (int i = 0; i < 4; i++) any_trip |= m_trip[i];
      if (!any_trip) m_fv = 0;
      else if (!m_fv) begin
        m_fv = 1;
        for (int i = 3; i >= 0; i--) if (new_trip[i]) m_fch = i;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e.warning[i]   = m_armed[i] && (m_age[i] >= WARN);
      e.triggered[i] = m_trip[i];
      e.early[i]     = m_early[i];
    end
    e.force_reset = (m_pulse_left > 0);
    e.fault_valid = m_fv;
    e.fault_ch    = 2'(m_fch);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] en, input logic [3:0] hb, input logic [3:0] cl, input logic r);
    @(negedge clk);
    enable = en; heartbeat = hb; clr = cl; rst = r;
    model(en, hb, cl, r);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("warning", 32'(warning), 32'(e.warning));
        chk("triggered", 32'(triggered), 32'(e.triggered));
        chk("force_reset", 32'(force_reset), 32'(e.force_reset));
        chk("fault_valid", 32'(fault_valid), 32'(e.fault_valid));
        if (e.fault_valid) chk("fault_ch", 32'(fault_ch), 32'(e.fault_ch));
`ifdef WDT_WINDOW_EN
        chk("early_kick", 32'(early_kick), 32'(e.early));
`endif
      end
    end
  end

  initial begin
    int warn_edge, trip_edge, trip2, trip3, pulses, bad;
    logic [3:0] ren, rhb, rcl;

    step(4'h0, 4'h0, 4'h0, 1'b1);
    @(posedge clk); #2;
    chk("reset_outputs", {26'd0, warning, triggered, force_reset, fault_valid}, 32'd0);

    // Single channel timeout: warning at edge 13, trip at edge 17, 4-cycle pulse.
    warn_edge = 0; trip_edge = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step(4'h1, 4'h0, 4'h0, 1'b0);
      @(posedge clk); #2;
      if (warning[0] && warn_edge == 0) warn_edge = k;
      if (triggered[0] && trip_edge == 0) trip_edge = k;
      if (force_reset) pulses++;
    end
    chk("t1_warn_edge", warn_edge, 13);
    chk("t1_trip_edge", trip_edge, 17);
    chk("t1_pulse_len", pulses, RP);
    chk("t1_fault", {fault_valid, fault_ch}, 3'b100);

    // Clear with enable held: flags drop next edge, then re-trip 17 edges later.
    step(4'h1, 4'h0, 4'h1, 1'b0);
    @(posedge clk); #2;
    chk("t4_trig_cleared", 32'(triggered[0]), 0);
    chk("t4_fv_cleared", 32'(fault_valid), 0);
    trip_edge = 0;
    for (int k = 1; k <= 25; k++) begin
      step(4'h1, 4'h0, 4'h0, 1'b0);
      @(posedge clk); #2;
      if (triggered[0] && trip_edge == 0) trip_edge = k;
    end
    chk("t4_retrip_edge", trip_edge, 17);
    step(4'h0, 4'h0, 4'h1, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0);

    // Regular kicks every 10 cycles never warn or trip.
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      step(4'h2, (k % 10 == 9) ? 4'h2 : 4'h0, 4'h0, 1'b0);
      @(posedge clk); #2;
      if (warning != 0 || triggered != 0 || force_reset) bad++;
    end
    chk("t2_no_alarm", bad, 0);
    step(4'h0, 4'h0, 4'h0, 1'b0);

    // Two channels tripping together: lowest index reported, single pulse.
    trip2 = 0; trip3 = 0; pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      step(4'hC, 4'h0, 4'h0, 1'b0);
      @(posedge clk); #2;
      if (triggered[2] && trip2 == 0) trip2 = k;
      if (triggered[3] && trip3 == 0) trip3 = k;
      if (force_reset) pulses++;
    end
    chk("t3_trip2_edge", trip2, 17);
    chk("t3_trip3_edge", trip3, 17);
    chk("t3_pulse_len", pulses, RP);
    chk("t3_fault", {fault_valid, fault_ch}, 3'b110);
    step(4'h0, 4'h0, 4'hC, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0);

    // Heartbeat exactly on the trip cycle wins; later trip aborted by reset mid-pulse.
    for (int k = 1; k <= 16; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 4'h0, 1'b0);
    @(posedge clk); #2;
    chk("t5_hb_wins", 32'(triggered[0]), 0);
    for (int k = 1; k <= 16; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    @(posedge clk); #2;
    chk("t5_trip_after_hb", {triggered[0], force_reset}, 2'b11);
    step(4'h1, 4'h0, 4'h0, 1'b1);
    @(posedge clk); #2;
    chk("t5_rst_mid_pulse", {26'd0, warning, triggered, force_reset, fault_valid}, 32'd0);
    step(4'h0, 4'h0, 4'h0, 1'b0);

`ifdef WDT_WINDOW_EN
    for (int k = 1; k <= 4; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 4'h0, 1'b0);
    @(posedge clk); #2;
    chk("t6_early_trip", {triggered[0], early_kick[0]}, 2'b11);
    step(4'h0, 4'h0, 4'h1, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 9; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 4'h0, 1'b0);
    @(posedge clk); #2;
    chk("t6_late_kick_ok", {triggered[0], early_kick[0]}, 2'b00);
    step(4'h0, 4'h0, 4'h0, 1'b0);
`endif

    // Random traffic against the model.
    ren = 4'hF;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 49) == 0) ren[i] = ~ren[i];
        rhb[i] = ($urandom_range(0, 13) == 0);
        rcl[i] = ($urandom_range(0, 29) == 0);
      end
      step(ren, rhb, rcl, ($urandom_range(0, 299) == 0));
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
